// File: rtl/wb_gpio_irq_if.sv
// wb_gpio_irq_if: classic Wishbone slave bus bundle for wb_gpio_irq
//   master drives adr/dat_i/we/cyc/stb/cti/bte; slave returns dat_o/ack/err/rty
interface wb_gpio_irq_if;
  logic [4:2]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO, per-pin direction, set/clr/tgl, input synchroniser, edge interrupts
//   wb_clk/wb_rst : clock, async active-high reset
//   wb            : classic single-cycle-ack Wishbone slave (registers 0..7)
//   gpio_i        : async pin inputs; gpio_o / gpio_dir_o : output data / drive enable
//   irq_o         : registered level interrupt
//   WB_GPIO_IRQ_EN defined builds MASK/EDGE/STATUS and irq_o; otherwise they read 0 and irq_o is 0
module wb_gpio_irq #(
  parameter int n_bits = 32,
  parameter int sync_stages = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  wb_gpio_irq_if.slave      wb,
  input  logic [n_bits-1:0] gpio_i,
  output logic [n_bits-1:0] gpio_o,
  output logic [n_bits-1:0] gpio_dir_o,
  output logic              irq_o
);
  localparam int sw = sync_stages * n_bits;
  logic              acc, wr;
  logic [2:0]        adr;
  logic [n_bits-1:0] wd, sync, go_n;
  logic [sw-1:0]     sr;
  logic [31:0]       rd;
  assign adr = wb.wb_adr_i;
  // ack low on the accept edge forces every second cycle between accepts
  assign acc = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr = acc & wb.wb_we_i;
  assign wd = wb.wb_dat_i[n_bits-1:0];
  assign sync = sr[sw-1 -: n_bits];
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign go_n = !wr ? gpio_o :
                adr == 3'd0 ? wd :
                adr == 3'd2 ? gpio_o | wd :
                adr == 3'd3 ? gpio_o & ~wd :
                adr == 3'd4 ? gpio_o ^ wd : gpio_o;
  // synchroniser as a shift register of whole pin vectors; top slice is the last stage
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) sr <= '0;
    else sr <= sw'({sr, gpio_i});
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      gpio_o <= '0;
      gpio_dir_o <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= acc;
      if (acc && !wb.wb_we_i) wb.wb_dat_o <= rd;
      if (wr && adr == 3'd1) gpio_dir_o <= wd;
      gpio_o <= go_n;
    end
`ifdef WB_GPIO_IRQ_EN
  logic [n_bits-1:0] mask, edge_sel, status, prev, evt, w1c;
  assign evt = (edge_sel & sync & ~prev) | (~edge_sel & prev & ~sync);
  assign w1c = {n_bits{wr && adr == 3'd7}} & wd;
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      prev <= '0;
      mask <= '0;
      edge_sel <= '0;
      status <= '0;
      irq_o <= 1'b0;
    end else begin
      prev <= sync;
      if (wr && adr == 3'd5) mask <= wd;
      if (wr && adr == 3'd6) edge_sel <= wd;
      // OR-ing the event after the clear lets a same-edge event win over W1C
      status <= (status & ~w1c) | evt;
      irq_o <= |(status & mask);
    end
`else
  assign irq_o = 1'b0;
`endif
  always_comb begin
    rd = '0;
    case (adr)
      3'd0: rd = 32'(sync);
      3'd1: rd = 32'(gpio_dir_o);
      3'd2, 3'd3, 3'd4: rd = 32'(gpio_o);
`ifdef WB_GPIO_IRQ_EN
      3'd5: rd = 32'(mask);
      3'd6: rd = 32'(edge_sel);
      3'd7: rd = 32'(status);
`endif
      default: rd = '0;
    endcase
  end
endmodule

// File: doc/wb_gpio_irq.md
# wb_gpio_irq

Parametrised Wishbone GPIO controller, 1–32 pins, with per-pin direction, atomic set/clear/toggle of outputs, configurable input synchroniser depth, and per-pin rising/falling edge interrupt capture. It sits on the peripheral Wishbone bus as a classic single-cycle-ack slave. It drives one level interrupt line to the interrupt controller.

## Interface
- `n_bits`, 32: pin count, range 1..32; register bits above `n_bits-1` read 0 and ignore writes.
- `sync_stages`, 2: input synchroniser flop count, range 1..3.
- `wb_clk` in 1: sole clock, all logic rising-edge.
- `wb_rst` in 1: asynchronous, active-high reset; clears every register.
- `wb_adr_i` in [4:2]: word register select.
- `wb_dat_i` in 32: write data.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i`, `wb_stb_i` in 1 each: cycle / strobe.
- `wb_cti_i` in 3, `wb_bte_i` in 2: ignored; every access is classic.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `wb_err_o`, `wb_rty_o` out 1 each: tied 0.
- `gpio_i` in `n_bits`: asynchronous pin inputs.
- `gpio_o` out `n_bits`: output data register.
- `gpio_dir_o` out `n_bits`: 1 = pin driven.
- `irq_o` out 1: registered level interrupt.

## Operation
- Register map by `wb_adr_i`:
  - 0 DATA: read returns synchronised inputs; write loads `gpio_o`.
  - 1 DIR: R/W.
  - 2 SET: write-1 sets `gpio_o` bits; reads `gpio_o`.
  - 3 CLR: write-1 clears; reads `gpio_o`.
  - 4 TGL: write-1 inverts; reads `gpio_o`.
  - 5 IRQ_MASK: R/W, 1 = enabled.
  - 6 IRQ_EDGE: R/W, 1 = rising, 0 = falling.
  - 7 IRQ_STATUS: read pending; write-1-to-clear.
- An access is accepted on an edge where `wb_cyc_i & wb_stb_i & !wb_ack_o`. At that edge:
  - a write updates the register;
  - a read loads `wb_dat_o`.
- `wb_ack_o` is high for exactly the next cycle, then low for at least one cycle. Back-to-back strobes are therefore accepted every second cycle.
- `wb_dat_o` holds its last value when no access is accepted.
- Synchroniser: `sync_stages` flops per pin; the last stage is `sync`.
- `prev` is `sync` delayed one cycle. A rising event is `!prev & sync`; a falling event is `prev & !sync`.
- An event of the selected polarity sets the STATUS bit regardless of mask and regardless of DIR, so output pins read back and interrupt too.
- Simultaneous W1C and new event on the same bit: the set wins and the bit stays 1.
- `irq_o` is registered from `|(IRQ_STATUS & IRQ_MASK)`.
- Changing IRQ_EDGE does not generate an event and does not alter STATUS.
- Reset (asynchronous, any time, including mid-access):
  - `gpio_o`, `gpio_dir_o`, MASK, EDGE, STATUS, `wb_dat_o`, `wb_ack_o`, `irq_o`, synchroniser and `prev` all go to 0.
  - An in-flight access is dropped with no ack.
  - A pin held high through reset raises a rising event after release. Software clears STATUS before unmasking.

## Timing
- Bus: write effect is visible on outputs the cycle ack is high. Read data is valid while ack is high.
- Pin change to DATA readback: the value is in `sync` after `sync_stages` edges and is returned by the next accepted read.
- Pin edge to STATUS bit: `sync_stages` + 1 edges.
- STATUS bit to `irq_o`: +1 edge.
- Worst case pin edge to `irq_o` is `sync_stages` + 2 edges (4 at default).
- W1C of last unmasked pending bit: `irq_o` falls one edge after the write edge.
- Pulses shorter than one `wb_clk` period may be missed. This is not an error.

## Configuration
- `WB_GPIO_IRQ_EN` defined: interrupt logic as above.
- `WB_GPIO_IRQ_EN` undefined:
  - MASK, EDGE and STATUS are not implemented, read 0 and ignore writes;
  - `prev` is not built;
  - `irq_o` is tied 0.
- DATA, DIR, SET, CLR and TGL are identical in both builds.

## Test plan
- Reset, then read all 8 addresses.
  - Required: all return 0; `gpio_o` = `gpio_dir_o` = 0; `irq_o` = 0; ack lasts one cycle per access.
- Write DATA = 0x0000_00F0, SET = 0x0000_0003, CLR = 0x0000_0010, TGL = 0x8000_0001.
  - Required: `gpio_o` = 0x8000_00E2; reads of addresses 2/3/4 all return it.
- `n_bits`=8: write DIR = 0xFFFF_FFFF, drive `gpio_i` = 0xA5.
  - Required: DIR reads 0x0000_00FF; DATA reads 0xA5 on a read accepted ≥2 edges after the change.
- MASK = 0x1, EDGE = 0x1, pin 0 goes 0→1.
  - Required: STATUS = 0x1 after 3 edges; `irq_o` high on the 4th.
  - Then drive 1→0: no new event.
  - Then W1C 0x1: `irq_o` low next cycle.
- W1C of bit 0 on the same edge a new rising event on pin 0 enters STATUS.
  - Required: STATUS stays 0x1 and `irq_o` stays high.
- Assert `wb_rst` mid-read, between accept and ack.
  - Required: ack never asserts, all outputs 0 asynchronously.
  - With `WB_GPIO_IRQ_EN` undefined, repeat the interrupt scenario: STATUS reads 0 and `irq_o` stays 0.
